lpf_interp: RTL and testbench
=============================

# lpf_interp

Transmit-side interpolating low-pass filter for the 8PSK modulator, the counterpart of the receive-side decimating filter chain. It accepts one baseband I or Q sample per RATE clocks through a valid/ready handshake and emits a smoothed, gain-normalised sample every clock. It uses an N-stage CIC interpolator: combs run at the low rate, zero-stuffing is applied, and integrators run at the clock rate. It sits between the symbol mapper/pulse-shaper and the DAC/upconverter path; one instance is used per rail.

## Interface
- W, 20: input and output sample width, two's complement
- RATE_LOG2, 3: log2 of interpolation factor R (R = 8)
- N_STAGES, 3: number of comb stages and number of integrator stages
- clk  in  1  sole clock; all logic is posedge clk
- reset  in  1  synchronous, active-high reset
- in_data  in  W  input sample
- in_valid  in  1  in_data is valid
- in_ready  out  1  holder can accept; a transfer occurs when in_valid && in_ready
- out_data  out  W  interpolated sample, updated every clk
- out_valid  out  1  out_data is meaningful; sticky high once set
- underflow  out  1  sticky; set when a tick finds the holder empty

## Operation
- Reset values: every register 0, state IDLE, phase 0, holder empty; outputs in_ready=1, out_data=0, out_valid=0, underflow=0.
- Holder: a one-entry register with a full flag.
  - in_ready = !full || tick.
  - On a transfer, holder loads in_data and full is set.
  - On a tick without a transfer, full is cleared.
  - There is no bypass: a sample accepted on a tick cycle is consumed at the next tick.
- State IDLE:
  - phase is held at 0 and no ticks occur.
  - The first transfer moves the state to RUN on the next cycle.
- State RUN:
  - phase increments mod R every cycle.
  - tick = (phase == 0), so the first RUN cycle is a tick.
  - RUN is left only by reset.
- Tick:
  - The comb input x is the holder value if full, else 0.
  - If the holder is empty, underflow is set.
  - Comb chain, N_STAGES cascaded first differences at tick rate: c_k = c_(k-1) − c_(k-1)_delayed. This is combinational from x; delay registers update only on tick.
  - The final comb result is registered into comb_q on the tick.
- Zero-stuff: the integrator input is comb_q on the cycle after a tick, otherwise 0.
- Integrators: N_STAGES cascaded registered accumulators, each updating every clk.
- Internal width WI = W + N_STAGES*RATE_LOG2.
  - All comb and integrator arithmetic is modulo 2^WI; wrap is intentional and exact.
  - No saturation.
- Output scaling:
  - out_data = integrator_N >>> ((N_STAGES−1)*RATE_LOG2), arithmetic shift (floor), truncated to W bits, then registered.
  - DC gain is exactly 1.
- out_valid rises on the cycle the first consumed sample's contribution reaches out_data, and stays high.

## Timing
- Latency: a sample consumed at a tick in cycle t first affects out_data in cycle t+N_STAGES+2, which is t+5 at defaults.
- Throughput:
  - One input per R clocks in RUN.
  - Upstream must present the next sample before the next tick, i.e. within R cycles of the last tick, to avoid underflow.
  - A transfer held off by !in_ready stalls only upstream; phase never stalls.
- Simultaneous tick + transfer with the holder full: the old value is consumed, the new value is loaded, and full stays 1.
- Reset in mid-operation: all state is cleared on the next edge. Any sample in flight is discarded, and out_valid and underflow drop.

## Structure
- Shared package es8psk_pkg holds:
  - the constant functions for WI and the output shift amount;
  - state encoding IDLE/RUN;
  - default W/RATE_LOG2/N_STAGES constants shared with the receive chain.
- Natural sub-module: cic_interp_core. It contains the comb chain, zero-stuffing and the integrators, with ports clk, reset, tick, x[W], y[W].
- lpf_interp owns the holder, the phase/state machine, underflow and out_valid.

## Test plan
- Reset: assert reset 3 cycles with in_valid=1 → in_ready=1, out_data=0, out_valid=0, underflow=0, and no transfer is counted.
- Impulse: after reset, send 64, then zeros every R cycles → out_data from the first affected cycle equals 1,3,6,10,15,21,28,36,42,46,48,48,46,42,36,28,21,15,10,6,3,1, then 0. Sum of outputs = 512; underflow=0.
- DC step: feed a constant 1000 every tick → out_data settles to exactly 1000 within 3R cycles and stays; same with −524288 (full-scale negative) → settles to −524288 with no wrap artefacts.
- Underflow: run steadily, then withhold one sample across a tick → underflow goes 1 on the following cycle and stays 1; output shows a zero-input response; phase does not slip.
- Backpressure: hold in_valid=1 continuously → exactly one transfer per R cycles in RUN; a transfer on a tick cycle with the holder full keeps full=1 and is consumed at the next tick.
- Mid-run reset: random stream, assert reset for 1 cycle → the next cycle shows all outputs at reset values and state IDLE; a fresh impulse then reproduces the impulse sequence exactly.

Source files
------------

// File: rtl/es8psk_pkg.sv
// rtl/es8psk_pkg.sv - shared constants, state encoding and CIC sizing helpers for the 8PSK chains
package es8psk_pkg;

    localparam int DEF_W         = 20;
    localparam int DEF_RATE_LOG2 = 3;
    localparam int DEF_N_STAGES  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Internal CIC width: the interpolator grows by R^(N-1) at the output,
    // and the comb/integrator pair needs the full R^N of headroom.
    function automatic int cic_wi(input int w, input int rate_log2, input int n_stages);
        return w + n_stages * rate_log2;
    endfunction

    // Right shift that brings the R^(N-1) interpolator gain back to unity.
    function automatic int cic_out_shift(input int rate_log2, input int n_stages);
        return (n_stages - 1) * rate_log2;
    endfunction

endpackage

// File: rtl/cic_interp_core.sv
// rtl/cic_interp_core.sv - CIC interpolator datapath: tick-rate combs, zero-stuff, clock-rate integrators
module cic_interp_core
    import es8psk_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int RATE_LOG2 = DEF_RATE_LOG2,
    parameter int N_STAGES  = DEF_N_STAGES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    localparam int WI = cic_wi(W, RATE_LOG2, N_STAGES);
    localparam int SH = cic_out_shift(RATE_LOG2, N_STAGES);

    logic [WI-1:0] dly     [N_STAGES];
    logic [WI-1:0] comb_in [N_STAGES];
    logic [WI-1:0] comb_out;
    logic [WI-1:0] comb_q;
    logic          tick_d;
    logic [WI-1:0] stuffed;
    logic [WI-1:0] integ   [N_STAGES];
    logic          unused_integ_bits;

    // Comb chain: cascaded first differences, evaluated combinationally from x.
    always_comb begin
        logic [WI-1:0] c;
        c = {{(WI-W){x[W-1]}}, x};
        for (int k = 0; k < N_STAGES; k++) begin
            comb_in[k] = c;
            c = c - dly[k];
        end
        comb_out = c;
    end

    // Zero-stuff: the comb result enters the integrators for one clock only.
    assign stuffed = tick_d ? comb_q : '0;

    // Comb delays and comb result register advance only on ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_STAGES; k++) dly[k] <= '0;
            comb_q <= '0;
            tick_d <= 1'b0;
        end else begin
            tick_d <= tick;
            if (tick) begin
                for (int k = 0; k < N_STAGES; k++) dly[k] <= comb_in[k];
                comb_q <= comb_out;
            end
        end
    end

    // Integrators run every clock; wraparound is exact because the combs undo it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
            y <= '0;
        end else begin
            integ[0] <= integ[0] + stuffed;
            for (int k = 1; k < N_STAGES; k++) integ[k] <= integ[k] + integ[k-1];
            // Arithmetic shift right then truncate: selecting bits SH..SH+W-1 is exactly floor.
            y <= integ[N_STAGES-1][SH +: W];
        end
    end

    assign unused_integ_bits = ^integ[N_STAGES-1];

endmodule

// File: rtl/lpf_interp.sv
// rtl/lpf_interp.sv - transmit interpolating low-pass filter: input holder, tick sequencer, CIC core
module lpf_interp
    import es8psk_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int RATE_LOG2 = DEF_RATE_LOG2,
    parameter int N_STAGES  = DEF_N_STAGES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         underflow
);

    state_t               state;
    logic [RATE_LOG2-1:0] phase;
    logic [W-1:0]         holder;
    logic                 full;
    logic                 tick;
    logic                 xfer;
    logic [W-1:0]         x;
    logic [N_STAGES:0]    vpipe;

    assign tick     = (state == RUN) && (phase == '0);
    assign in_ready = !full || tick;
    assign xfer     = in_valid && in_ready;
    assign x        = full ? holder : '0;

    // Sequencer: idle until the first sample, then free-running phase counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (xfer) state <= RUN;
                end
                RUN: phase <= phase + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry holder; a load on a tick replaces the value being consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            holder <= '0;
            full   <= 1'b0;
        end else if (xfer) begin
            holder <= in_data;
            full   <= 1'b1;
        end else if (tick) begin
            full   <= 1'b0;
        end
    end

    // Sticky underflow and out_valid, the latter delayed to match the datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow <= 1'b0;
            vpipe     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (tick && !full) underflow <= 1'b1;
            vpipe     <= {vpipe[N_STAGES-1:0], tick && full};
            out_valid <= out_valid | vpipe[N_STAGES];
        end
    end

    cic_interp_core #(
        .W         (W),
        .RATE_LOG2 (RATE_LOG2),
        .N_STAGES  (N_STAGES)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .x     (x),
        .y     (out_data)
    );

endmodule

// File: tb/tb_lpf_interp.sv
// tb/tb_lpf_interp.sv - directed self-checking bench for lpf_interp
module tb_lpf_interp;
    import es8psk_pkg::*;

    localparam int W = 20;

    logic         clk;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         underflow;

    int checks;
    int errors;

    int imp_tab [22] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48,
                         48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

    lpf_interp dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 20'd123;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b1 || out_data !== '0 || out_valid !== 1'b0 || underflow !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: ready=%b data=%0d valid=%b uf=%b, want 1 0 0 0",
                         i, in_ready, out_data, out_valid, underflow);
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || dut.state !== IDLE || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_transfer: ready=%b state=%0d valid=%b, want 1 IDLE 0",
                     in_ready, dut.state, out_valid);
        end
    endtask

    // Expects to be entered right after reset release; sends 64 then zeros.
    task automatic impulse_run(input string tag);
        int w0;
        int k;
        int sum;
        logic [W-1:0] exp_v;
        w0  = -1;
        sum = 0;
        in_valid = 1'b1;
        in_data  = 20'd64;
        for (int c = 0; c < 50; c++) begin
            if (w0 >= 0) begin
                if (c == w0 + 5) begin
                    checks++;
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_valid_early: out_valid=%b, want 0", tag, out_valid);
                    end
                end
                if (c == w0 + 6) begin
                    checks++;
                    if (out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL %s_valid_rise: out_valid=%b, want 1", tag, out_valid);
                    end
                end
                k = c - (w0 + 6);
                if (k >= 0 && k < 30) begin
                    exp_v = (k < 22) ? W'(imp_tab[k]) : '0;
                    sum += int'($signed(out_data));
                    checks++;
                    if (out_data !== exp_v) begin
                        errors++;
                        $display("FAIL %s_sample k=%0d: got %0d, want %0d", tag, k,
                                 $signed(out_data), $signed(exp_v));
                    end
                end
            end
            if (w0 < 0 && in_valid && in_ready) w0 = c;
            step();
            if (w0 >= 0) in_data = '0;
        end
        checks++;
        if (sum != 512) begin
            errors++;
            $display("FAIL %s_sum: got %0d, want 512", tag, sum);
        end
        checks++;
        if (underflow !== 1'b0 || w0 != 0) begin
            errors++;
            $display("FAIL %s_underflow: uf=%b first_xfer=%0d, want 0 and 0", tag, underflow, w0);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_impulse();
        do_reset();
        impulse_run("impulse");
    endtask

    task automatic test_dc(input logic [W-1:0] val, input string tag);
        do_reset();
        in_valid = 1'b1;
        in_data  = val;
        for (int c = 0; c < 60; c++) begin
            if (c >= 40 && c < 56) begin
                checks++;
                if (out_data !== val) begin
                    errors++;
                    $display("FAIL %s_settle c=%0d: got %0d, want %0d", tag, c,
                             $signed(out_data), $signed(val));
                end
            end
            step();
        end
        checks++;
        if (underflow !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_flags: uf=%b valid=%b, want 0 1", tag, underflow, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_underflow();
        int w;
        int rel;
        do_reset();
        in_valid = 1'b1;
        in_data  = 20'd1000;
        w = -1;
        for (int c = 0; c < 110; c++) begin
            if (w < 0 && c >= 60 && in_valid && in_ready) w = c;
            if (w >= 0) begin
                rel = c - w;
                if (rel == 16) begin
                    checks++;
                    if (underflow !== 1'b0) begin
                        errors++;
                        $display("FAIL uf_before: underflow=%b, want 0", underflow);
                    end
                end
                if (rel == 17 || rel == 40) begin
                    checks++;
                    if (underflow !== 1'b1) begin
                        errors++;
                        $display("FAIL uf_set rel=%0d: underflow=%b, want 1", rel, underflow);
                    end
                end
                if (rel == 20) begin
                    checks++;
                    if (out_data !== 20'd1000) begin
                        errors++;
                        $display("FAIL uf_pre_dip: got %0d, want 1000", $signed(out_data));
                    end
                end
                if (rel == 21) begin
                    checks++;
                    if (out_data !== 20'd984) begin
                        errors++;
                        $display("FAIL uf_dip1: got %0d, want 984", $signed(out_data));
                    end
                end
                if (rel == 22) begin
                    checks++;
                    if (out_data !== 20'd953) begin
                        errors++;
                        $display("FAIL uf_dip2: got %0d, want 953", $signed(out_data));
                    end
                end
                if (rel == 23) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL uf_phase_hold: in_ready=%b, want 0", in_ready);
                    end
                end
                if (rel == 24) begin
                    checks++;
                    if (in_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL uf_phase_tick: in_ready=%b, want 1", in_ready);
                    end
                end
                in_valid = !(rel >= 1 && rel <= 15);
            end
            step();
        end
        checks++;
        if (w < 0) begin
            errors++;
            $display("FAIL uf_no_steady_xfer: got none, want a transfer");
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n_xfer;
        int last;
        int bad_gap;
        do_reset();
        in_valid = 1'b1;
        in_data  = 20'd1;
        n_xfer  = 0;
        last    = -1;
        bad_gap = 0;
        for (int c = 0; c < 66; c++) begin
            if (c == 2) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full_kept: in_ready=%b, want 0", in_ready);
                end
            end
            if (in_valid && in_ready) begin
                if (c >= 1 && c <= 64) n_xfer++;
                if (c > 1 && last >= 1 && c - last != 8) bad_gap++;
                last = c;
                in_data = in_data + 1'b1;
            end
            step();
        end
        checks++;
        if (n_xfer != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d transfers, want 8", n_xfer);
        end
        checks++;
        if (bad_gap != 0 || last != 57 + 8) begin
            errors++;
            $display("FAIL bp_spacing: bad_gaps=%0d last=%0d, want 0 and 65", bad_gap, last);
        end
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_underflow: got %b, want 0", underflow);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_midrun_reset();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            step();
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_data !== '0 || out_valid !== 1'b0 ||
            underflow !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL midrun_reset: ready=%b data=%0d valid=%b uf=%b state=%0d, want 1 0 0 0 IDLE",
                     in_ready, out_data, out_valid, underflow, dut.state);
        end
        reset = 1'b0;
        impulse_run("post_reset");
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_impulse();
        test_dc(20'd1000, "dc_pos");
        test_dc(20'h80000, "dc_neg");
        test_underflow();
        test_back_to_back();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
